idli_redirect_m: RTL and testbench



---
 rtl/idli_redirect_m_if.sv | 35 +++
 rtl/idli_redirect_m.sv | 121 ++++++++++++
 tb/tb_idli_redirect_m.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/idli_redirect_m_if.sv
// Signal bundle between the serial branch-target unit and its PC / sequencer side.
// Link ports exist only when IDLI_REDIR_LINK_EN is defined.
interface idli_redirect_m_if;
  logic [1:0] i_redir_ctr;
  logic       i_redir_req;
  logic       i_redir_rel;
  logic [3:0] i_redir_pc;
  logic [3:0] i_redir_opnd;
  logic       i_redir_cond;
  logic       o_redir;
  logic [3:0] o_redir_data;
  logic       o_redir_busy;
`ifdef IDLI_REDIR_LINK_EN
  logic       o_redir_link;
  logic [3:0] o_redir_link_data;

  modport master (
    input  i_redir_ctr, i_redir_req, i_redir_rel, i_redir_pc, i_redir_opnd, i_redir_cond,
    output o_redir, o_redir_data, o_redir_busy, o_redir_link, o_redir_link_data
  );
  modport slave (
    output i_redir_ctr, i_redir_req, i_redir_rel, i_redir_pc, i_redir_opnd, i_redir_cond,
    input  o_redir, o_redir_data, o_redir_busy, o_redir_link, o_redir_link_data
  );
`else
  modport master (
    input  i_redir_ctr, i_redir_req, i_redir_rel, i_redir_pc, i_redir_opnd, i_redir_cond,
    output o_redir, o_redir_data, o_redir_busy
  );
  modport slave (
    output i_redir_ctr, i_redir_req, i_redir_rel, i_redir_pc, i_redir_opnd, i_redir_cond,
    input  o_redir, o_redir_data, o_redir_busy
  );
`endif
endinterface

// File: rtl/idli_redirect_m.sv
// Bit-serial branch/jump target unit: captures a 16b target one 4b slice per cycle and
// replays it to the PC over the following word. Optional link write-back: IDLI_REDIR_LINK_EN.
module idli_redirect_m #(
  parameter int SLICES = 4
) (
  input logic               i_redir_gck,
  input logic               i_redir_rst_n,
  idli_redirect_m_if.master bus
);
  typedef logic [1:0] ctr_t;
  typedef logic [3:0] slice_t;

  if (SLICES != 4) begin : g_slices_check
    $error("idli_redirect_m: only SLICES=4 is supported");
  end

  logic        cap_q;
  logic        drv_q;
  logic        carry_q;
  logic        rel_q;
  logic [15:0] tgt_q;

  logic   start;
  logic   capturing;
  logic   last;
  logic   rel_eff;
  logic   cin;
  logic   sum_c;
  slice_t sum_s;
  slice_t cap_s;

  // A capture only starts on slice 0 and never while one is already running.
  assign start     = bus.i_redir_req && (bus.i_redir_ctr == 2'd0) && !cap_q;
  assign capturing = start || cap_q;
  assign last      = (bus.i_redir_ctr == 2'd3);
  assign rel_eff   = start ? bus.i_redir_rel : rel_q;
  assign cin       = start ? 1'b0 : carry_q;

  assign {sum_c, sum_s} = {1'b0, bus.i_redir_pc} + {1'b0, bus.i_redir_opnd} + {4'b0000, cin};
  assign cap_s          = rel_eff ? sum_s : bus.i_redir_opnd;

  // While driving, the outgoing slice rotates back in; an overlapping capture replaces it instead.
  always_ff @(posedge i_redir_gck or negedge i_redir_rst_n) begin
    if (!i_redir_rst_n) begin
      cap_q   <= 1'b0;
      drv_q   <= 1'b0;
      carry_q <= 1'b0;
      rel_q   <= 1'b0;
      tgt_q   <= '0;
    end else begin
      if (start) begin
        cap_q <= 1'b1;
        rel_q <= bus.i_redir_rel;
      end else if (cap_q && last) begin
        cap_q <= 1'b0;
      end

      if (capturing) begin
        carry_q <= last ? 1'b0 : sum_c;
        tgt_q   <= {cap_s, tgt_q[15:4]};
      end else if (drv_q) begin
        tgt_q   <= {tgt_q[3:0], tgt_q[15:4]};
      end

      if (last) begin
        drv_q <= cap_q && bus.i_redir_cond;
      end
    end
  end

  assign bus.o_redir      = drv_q;
  assign bus.o_redir_data = drv_q ? tgt_q[3:0] : 4'h0;
  assign bus.o_redir_busy = cap_q || drv_q || (bus.i_redir_req && (bus.i_redir_ctr == 2'd0));

`ifdef IDLI_REDIR_LINK_EN
  logic [15:0] link_q;
  logic        link_carry_q;
  logic        link_c;
  slice_t      link_s;

  // Return address is pc + 1, serially incremented alongside the target.
  assign {link_c, link_s} = {1'b0, bus.i_redir_pc} + {4'b0000, (start ? 1'b1 : link_carry_q)};

  always_ff @(posedge i_redir_gck or negedge i_redir_rst_n) begin
    if (!i_redir_rst_n) begin
      link_q       <= '0;
      link_carry_q <= 1'b0;
    end else if (capturing) begin
      link_q       <= {link_s, link_q[15:4]};
      link_carry_q <= last ? 1'b0 : link_c;
    end else if (drv_q) begin
      link_q       <= {link_q[3:0], link_q[15:4]};
    end
  end

  assign bus.o_redir_link      = drv_q;
  assign bus.o_redir_link_data = drv_q ? link_q[3:0] : 4'h0;
`endif

`ifndef SYNTHESIS
  ctr_t ctr_prev;
  logic ctr_prev_vld;

  always_ff @(posedge i_redir_gck or negedge i_redir_rst_n) begin
    if (!i_redir_rst_n) begin
      ctr_prev     <= '0;
      ctr_prev_vld <= 1'b0;
    end else begin
      ctr_prev     <= bus.i_redir_ctr;
      ctr_prev_vld <= 1'b1;
    end
  end

  always @(posedge i_redir_gck) begin
    if (i_redir_rst_n && ctr_prev_vld) begin
      assert (bus.i_redir_ctr == ctr_t'(ctr_prev + 2'd1))
        else $error("idli_redirect_m: slice counter discontinuity");
    end
  end
`endif
endmodule

// File: tb/tb_idli_redirect_m.sv
// Directed bench for idli_redirect_m: a word-level target model plus literal slice checks.
module tb_idli_redirect_m;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst_n;

  idli_redirect_m_if bus();

  idli_redirect_m #(.SLICES(4)) dut (
    .i_redir_gck   (clk),
    .i_redir_rst_n (rst_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Expected outputs per cycle index, filled by the word-level model.
  logic       exp_redir [DEPTH];
  logic [3:0] exp_data  [DEPTH];
  logic       exp_busy  [DEPTH];
  logic       lit_vld   [DEPTH];
  logic [3:0] lit_data  [DEPTH];

  int   cyc;
  int   n_vec;
  int   n_bad;
  logic run;

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s cycle %0d: got %h, required %h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (run && cyc < DEPTH) begin
      checkOutput("redir", {3'b000, bus.o_redir}, {3'b000, exp_redir[cyc]});
      checkOutput("redir_data", bus.o_redir_data, exp_data[cyc]);
      checkOutput("busy", {3'b000, bus.o_redir_busy}, {3'b000, exp_busy[cyc]});
      if (lit_vld[cyc]) checkOutput("literal_slice", bus.o_redir_data, lit_data[cyc]);
    end
  end

  task automatic clearModel(input int from);
    for (int i = from; i < DEPTH; i++) begin
      exp_redir[i] = 1'b0;
      exp_data[i]  = 4'h0;
      exp_busy[i]  = 1'b0;
      lit_vld[i]   = 1'b0;
      lit_data[i]  = 4'h0;
    end
  endtask

  task automatic applyStimulus(input logic req, input logic rel, input logic [3:0] pc_s,
                               input logic [3:0] opnd_s, input logic cond);
    bus.i_redir_ctr  = 2'(cyc % 4);
    bus.i_redir_req  = req;
    bus.i_redir_rel  = rel;
    bus.i_redir_pc   = pc_s;
    bus.i_redir_opnd = opnd_s;
    bus.i_redir_cond = cond;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One 4-cycle word; req is raised only in slice req_slot (-1 for none).
  task automatic runWord(input int req_slot, input logic rel, input logic [15:0] pc,
                         input logic [15:0] opnd, input logic cond,
                         input logic [15:0] lit_tgt, input logic use_lit);
    int          base;
    logic [15:0] tgt;
    base = cyc;
    if (req_slot == 0) begin
      for (int k = 0; k < 4; k++) exp_busy[base + k] = 1'b1;
      if (cond) begin
        tgt = rel ? (pc + opnd) : opnd;
        for (int k = 0; k < 4; k++) begin
          exp_redir[base + 4 + k] = 1'b1;
          exp_data[base + 4 + k]  = tgt[4*k +: 4];
          exp_busy[base + 4 + k]  = 1'b1;
          if (use_lit) begin
            lit_vld[base + 4 + k]  = 1'b1;
            lit_data[base + 4 + k] = lit_tgt[4*k +: 4];
          end
        end
      end
    end
    for (int k = 0; k < 4; k++)
      applyStimulus(k == req_slot, rel, pc[4*k +: 4], opnd[4*k +: 4], (k == 3) ? cond : ~cond);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    cyc   = 0;
    run   = 1'b0;
    clearModel(0);
    rst_n            = 1'b0;
    bus.i_redir_ctr  = 2'd0;
    bus.i_redir_req  = 1'b0;
    bus.i_redir_rel  = 1'b0;
    bus.i_redir_pc   = 4'h0;
    bus.i_redir_opnd = 4'h0;
    bus.i_redir_cond = 1'b0;
    @(posedge clk);
    #1;
    run = 1'b1;

    repeat (4) applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    repeat (2) runWord(-1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Relative taken with carry rippling through slices 0..2: 0x12FE + 4 = 0x1302.
    runWord(0, 1'b1, 16'h12FE, 16'h0004, 1'b1, 16'h1302, 1'b1);
    runWord(-1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Relative wrap: 0xFFFE + 3 = 0x0001 mod 2^16.
    runWord(0, 1'b1, 16'hFFFE, 16'h0003, 1'b1, 16'h0001, 1'b1);
    runWord(-1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Absolute target ignores the PC.
    runWord(0, 1'b0, 16'h1234, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1);
    runWord(-1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Not taken, then a misaligned req that must be ignored.
    runWord(0, 1'b1, 16'h0100, 16'h0020, 1'b0, 16'h0000, 1'b0);
    runWord(-1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    runWord(2, 1'b1, 16'h5555, 16'h1111, 1'b1, 16'h0000, 1'b0);
    runWord(-1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Back-to-back taken absolute branches, then back-to-back relative ones.
    runWord(0, 1'b0, 16'h0000, 16'h1000, 1'b1, 16'h1000, 1'b1);
    runWord(0, 1'b0, 16'h0000, 16'h2000, 1'b1, 16'h2000, 1'b1);
    runWord(0, 1'b1, 16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b1);
    runWord(0, 1'b1, 16'h0FFF, 16'h0001, 1'b1, 16'h1000, 1'b1);
    runWord(-1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Reset in the middle of a drive word must drop the redirect at once.
    runWord(0, 1'b0, 16'h1234, 16'hABCD, 1'b1, 16'hABCD, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    bus.i_redir_ctr = 2'(cyc % 4);
    bus.i_redir_req = 1'b0;
    #1;
    rst_n = 1'b0;
    clearModel(cyc);
    #1;
    checkOutput("reset_redir", {3'b000, bus.o_redir}, 4'h0);
    checkOutput("reset_data", bus.o_redir_data, 4'h0);
    checkOutput("reset_busy", {3'b000, bus.o_redir_busy}, 4'h0);
    @(posedge clk);
    #1;
    cyc++;
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    repeat (2) runWord(-1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
